neopixel_frame_sequencer: RTL

Frame-level controller for a WS2812/NeoPixel strip on the `osc25m` domain. On a `start` pulse it fetches `NUM_PIXELS` 24-bit GRB words from an external pixel buffer. It serializes each word MSB-first as WS2812 bit waveforms on `dout`, then holds the line low for the latch/reset interval. It sits between the pattern/fade logic that fills the pixel buffer and the strip data pin.

---
 rtl/neopixel_pkg.sv | 34 +++
 rtl/ws2812_bit_encoder.sv | 57 +++++
 rtl/neopixel_frame_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel frame sequencer: FSM states,
// 25 MHz WS2812 timing defaults, word geometry and the channel dimming helper.
package neopixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    localparam int PIXEL_W = 24;
    localparam int CHAN_W  = 8;

    localparam int DEF_T0H          = 9;
    localparam int DEF_T1H          = 18;
    localparam int DEF_TBIT         = 31;
    localparam int DEF_RESET_CYCLES = 1250;

    // Scales every channel by (brightness+1)/256; 255 is an exact pass-through.
    function automatic logic [PIXEL_W-1:0] dim_pixel(input logic [PIXEL_W-1:0] p,
                                                     input logic [CHAN_W-1:0]  b);
        logic [PIXEL_W-1:0] r;
        logic [15:0]        prod;
        r = '0;
        for (int i = 0; i < PIXEL_W / CHAN_W; i++) begin
            prod = 16'(p[i*CHAN_W +: CHAN_W]) * (16'(b) + 16'd1);
            r[i*CHAN_W +: CHAN_W] = prod[15:8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Generates one WS2812 bit waveform per bit_go: high for T1H/T0H cycles, then low
// until TBIT cycles have elapsed. bit_done marks the last cycle of the bit.
module ws2812_bit_encoder
    import neopixel_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic osc25m,
    input  logic rst,
    input  logic bit_in,
    input  logic bit_go,
    output logic dout,
    output logic bit_done
);

    localparam int CW = $clog2(TBIT + 1);

    logic          active, nxt_active;
    logic          cur_bit, nxt_bit;
    logic [CW-1:0] cnt, nxt_cnt;

    assign bit_done = active && (cnt == CW'(TBIT - 1));

    // A bit_go on the bit_done cycle starts the next bit with no idle gap.
    always_comb begin
        nxt_active = active;
        nxt_bit    = cur_bit;
        nxt_cnt    = cnt;
        if (bit_go) begin
            nxt_active = 1'b1;
            nxt_bit    = bit_in;
            nxt_cnt    = '0;
        end else if (bit_done) begin
            nxt_active = 1'b0;
        end else if (active) begin
            nxt_cnt = cnt + 1'b1;
        end
    end

    // dout is registered so the strip pin never sees compare glitches.
    always_ff @(posedge osc25m or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            cur_bit <= 1'b0;
            cnt     <= '0;
            dout    <= 1'b0;
        end else begin
            active  <= nxt_active;
            cur_bit <= nxt_bit;
            cnt     <= nxt_cnt;
            dout    <= nxt_active && (nxt_cnt < (nxt_bit ? CW'(T1H) : CW'(T0H)));
        end
    end

endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Fetches NUM_PIXELS GRB words from a sync-read buffer and streams them to a WS2812
// strip, then holds the latch interval. NEOPIXEL_GLOBAL_DIM_EN adds a brightness input.
module neopixel_frame_sequencer
    import neopixel_pkg::*;
#(
    parameter  int NUM_PIXELS   = 8,
    parameter  int T0H          = DEF_T0H,
    parameter  int T1H          = DEF_T1H,
    parameter  int TBIT         = DEF_TBIT,
    parameter  int RESET_CYCLES = DEF_RESET_CYCLES,
    localparam int AW           = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic               osc25m,
    input  logic               rst,
    input  logic               start,
    output logic [AW-1:0]      pix_addr,
    input  logic [PIXEL_W-1:0] pix_data,
`ifdef NEOPIXEL_GLOBAL_DIM_EN
    input  logic [CHAN_W-1:0]  brightness,
`endif
    output logic               busy,
    output logic               done,
    output logic               dout
);

    localparam int TMAX = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
    localparam int TCW  = $clog2(TMAX + 1);

    state_t             state, nxt_state;
    logic [PIXEL_W-2:0] sreg;
    logic [4:0]         bit_cnt;
    logic [TCW-1:0]     lat_cnt;
    logic [PIXEL_W-1:0] load_word;
    logic               bit_go, bit_in, bit_done;
    logic               last_pixel;

`ifdef NEOPIXEL_GLOBAL_DIM_EN
    assign load_word = dim_pixel(pix_data, brightness);
`else
    assign load_word = pix_data;
`endif

    assign last_pixel = (pix_addr == AW'(NUM_PIXELS - 1));
    assign busy       = (state != ST_IDLE);

    ws2812_bit_encoder #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT)) u_enc (
        .osc25m  (osc25m),
        .rst     (rst),
        .bit_in  (bit_in),
        .bit_go  (bit_go),
        .dout    (dout),
        .bit_done(bit_done)
    );

    always_ff @(posedge osc25m or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt_state;
    end

    // The MSB goes straight from the load word; sreg holds the remaining 23 bits.
    always_comb begin
        nxt_state = state;
        bit_go    = 1'b0;
        bit_in    = sreg[PIXEL_W-2];
        case (state)
            ST_IDLE:  if (start) nxt_state = ST_FETCH;
            ST_FETCH: nxt_state = ST_LOAD;
            ST_LOAD: begin
                nxt_state = ST_SHIFT;
                bit_go    = 1'b1;
                bit_in    = load_word[PIXEL_W-1];
            end
            ST_SHIFT: begin
                if (bit_done) begin
                    if (bit_cnt != 5'd0) bit_go = 1'b1;
                    else                 nxt_state = last_pixel ? ST_LATCH : ST_FETCH;
                end
            end
            ST_LATCH: if (lat_cnt == TCW'(RESET_CYCLES - 1)) nxt_state = ST_IDLE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge osc25m or posedge rst) begin
        if (rst) begin
            pix_addr <= '0;
            sreg     <= '0;
            bit_cnt  <= '0;
            lat_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            done    <= (state == ST_LATCH) && (nxt_state == ST_IDLE);
            lat_cnt <= (state == ST_LATCH) ? lat_cnt + 1'b1 : '0;
            case (state)
                ST_IDLE: if (start) pix_addr <= '0;
                ST_LOAD: begin
                    sreg    <= load_word[PIXEL_W-2:0];
                    bit_cnt <= 5'(PIXEL_W - 1);
                end
                ST_SHIFT: begin
                    if (bit_done) begin
                        if (bit_cnt != 5'd0) begin
                            sreg    <= sreg << 1;
                            bit_cnt <= bit_cnt - 5'd1;
                        end else if (!last_pixel) begin
                            pix_addr <= pix_addr + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
